// File: rtl/nn_isa_pkg.sv
// Shared ISA definitions for the fetch/decode front end: opcode encodings,
// instruction geometry and the fetch FSM state type.
package nn_isa_pkg;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int OPC_LSB = INSTR_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SINN = 4'b0011;
    localparam logic [OPC_W-1:0] OP_MAC  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'b1001;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1011;
    localparam logic [OPC_W-1:0] OP_LD   = 4'b1110;
    localparam logic [OPC_W-1:0] OP_ST   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding {instruction, pc}; head is always in head_q so the
// consumer sees a registered output that holds while stalled.
module fetch_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && (count_q != 2'd2);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: if (push_ok) begin
                head_d  = din_i;
                count_d = 2'd1;
            end
            2'd1: begin
                if (push_ok && pop_ok) begin
                    head_d = din_i;
                end else if (push_ok) begin
                    tail_d  = din_i;
                    count_d = 2'd2;
                end else if (pop_ok) begin
                    count_d = 2'd0;
                end
            end
            2'd2: if (pop_ok) begin
                head_d  = tail_q;
                count_d = 2'd1;
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch stage: walks the PC through instruction memory, buffers
// words in a 2-entry queue and stops at HALT once decode has drained it.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = nn_isa_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [3:0]         opcode,
    output logic               busy,
    output logic               halted
);
    localparam int EW = INSTR_W + ADDR_W;

    nn_isa_pkg::fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [EW-1:0]     head;
    logic [1:0]        count;
    logic              push, pop;

    // Request depends only on registered state, so memory never sees a
    // combinational path from its own ack back to req.
    assign imem_req  = (state_q == nn_isa_pkg::FETCH) && (count != 2'd2);
    assign imem_addr = pc_q;
    assign push      = imem_req && imem_ack;
    assign pop       = instr_valid && instr_ready;

    fetch_fifo #(.W(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({imem_rdata, pc_q}),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            nn_isa_pkg::IDLE: if (start) begin
                state_d = nn_isa_pkg::FETCH;
                pc_d    = RESET_PC;
            end
            nn_isa_pkg::FETCH: if (push) begin
                pc_d = pc_q + 1'b1;
                if (imem_rdata[INSTR_W-1 -: 4] == nn_isa_pkg::OP_HALT)
                    state_d = nn_isa_pkg::DRAIN;
            end
            // Look at the post-pop occupancy so halted rises the cycle after
            // the HALT word leaves the queue.
            nn_isa_pkg::DRAIN: if (count == 2'd0 || (count == 2'd1 && pop))
                state_d = nn_isa_pkg::HALTED;
            nn_isa_pkg::HALTED: state_d = nn_isa_pkg::HALTED;
            default: state_d = nn_isa_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= nn_isa_pkg::IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_valid = (count != 2'd0);
    assign instr       = head[EW-1 -: INSTR_W];
    assign instr_pc    = head[ADDR_W-1:0];
    assign opcode      = instr[INSTR_W-1 -: 4];
    assign busy        = (state_q == nn_isa_pkg::FETCH) || (state_q == nn_isa_pkg::DRAIN);
    assign halted      = (state_q == nn_isa_pkg::HALTED);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing steps plus randomized programs,
// wait states and backpressure checked against an in-order program stream.
module tb_instr_fetch_unit;
    import nn_isa_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, imem_ack, instr_ready;
    logic [15:0] imem_rdata, imem_addr, instr, instr_pc;
    logic        imem_req, instr_valid, busy, halted;
    logic [3:0]  opcode;

    logic        start2, ack2, req2, valid2, busy2, halted2;
    logic        ready2 = 1'b1;
    logic [15:0] rdata2, addr2, instr2, pc2;
    logic [3:0]  opc2;

    instr_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .busy(busy), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr_ready(ready2), .instr(instr2), .instr_pc(pc2),
        .opcode(opc2), .busy(busy2), .halted(halted2)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program memory and reference stream state
    logic [15:0] mem [0:63];
    int  ws = 0, wcnt = 0, acks = 0, run = 0;
    bit  hold_ack = 0, check_ws = 0, rand_ready = 0, halt_pend = 0;
    int  exp_pc = 0, exp_fetch = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] fa[$], pq[$], iq[$];

    // Memory responder: acks after ws idle request cycles
    initial begin
        imem_ack = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            imem_ack = 1'b0;
            if (imem_req && !hold_ack) begin
                if (wcnt >= ws) begin
                    imem_ack = 1'b1; imem_rdata = mem[imem_addr[5:0]]; wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    function automatic logic [15:0] mem2(input logic [15:0] a);
        case (a)
            16'hFFFE: mem2 = 16'h0123;
            16'hFFFF: mem2 = 16'h0456;
            16'h0000: mem2 = 16'hB000;
            default:  mem2 = 16'h1FFF;
        endcase
    endfunction

    initial begin
        ack2 = 1'b0; rdata2 = '0;
        forever begin
            @(posedge clk); #2;
            ack2 = req2; rdata2 = mem2(addr2);
        end
    end

    // Monitor: every fetch and every consumed word must follow program order
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (run > 0 && imem_addr == last_addr) run++; else run = 1;
                last_addr = imem_addr;
                if (imem_ack) begin
                    acks++;
                    chk("ack_addr", imem_addr, exp_fetch[15:0]);
                    exp_fetch++;
                    if (check_ws) chk("addr_hold", run, ws + 1);
                    run = 0;
                end
            end else run = 0;
            if (halt_pend) begin
                chk("halted_after_pop", halted, 1);
                halt_pend = 0;
            end
            if (instr_valid && instr_ready) begin
                chk("instr", instr, mem[exp_pc[5:0]]);
                chk("instr_pc", instr_pc, exp_pc[15:0]);
                chk("opcode", opcode, mem[exp_pc[5:0]][15:12]);
                if (mem[exp_pc[5:0]][15:12] == OP_HALT) begin
                    chk("halted_early", halted, 0);
                    halt_pend = 1;
                end
                exp_pc++;
            end
            if (req2 && ack2) fa.push_back(addr2);
            if (valid2 && ready2) begin
                pq.push_back(pc2); iq.push_back(instr2);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        exp_pc = 0; exp_fetch = 0; acks = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic gen_prog(input int n);
        logic [3:0] ops [8];
        ops = '{OP_NOP, OP_ADD, OP_MUL, OP_SINN, OP_MAC, OP_ADDI, OP_LD, OP_ST};
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < n; i++) mem[i] = {ops[$urandom_range(0, 7)], 12'($urandom)};
        mem[n] = {OP_HALT, 12'($urandom)};
    endtask

    task automatic run_to_halt(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin
            if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
            cyc(1); n++;
        end
        chk(tag, halted, 1);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_req"}, imem_req, 0);
        chk({pfx, "_addr"}, imem_addr, 0);
        chk({pfx, "_valid"}, instr_valid, 0);
        chk({pfx, "_instr"}, instr, 0);
        chk({pfx, "_ipc"}, instr_pc, 0);
        chk({pfx, "_opc"}, opcode, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_halted"}, halted, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'hB0B0;
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h4567; mem[3] = 16'hB000;

        // Reset with start held, then zero-wait streaming to HALT
        start = 1'b1; instr_ready = 1'b1;
        cyc(3);
        check_reset("rst");
        rst_n = 1'b1;
        chk("req_before_start", imem_req, 0);
        cyc(1); start = 1'b0;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_valid", instr_valid, 0);
        chk("busy", busy, 1);
        cyc(1); chk("stream_pc0", instr_pc, 0); chk("stream_v0", instr_valid, 1);
        cyc(1); chk("stream_pc1", instr_pc, 1);
        cyc(1); chk("stream_pc2", instr_pc, 2);
        cyc(1); chk("stream_pc3", instr_pc, 3); chk("drain_req", imem_req, 0);
        cyc(1); chk("halted", halted, 1); chk("halted_busy", busy, 0);
        cyc(3); chk("no_fetch_past_halt", acks, 4); chk("halted_req", imem_req, 0);

        // Backpressure fills the queue, one pop re-enables the request
        do_reset();
        instr_ready = 1'b0;
        pulse_start();
        cyc(10);
        chk("bp_valid", instr_valid, 1);
        chk("bp_head", instr_pc, 0);
        chk("bp_req", imem_req, 0);
        chk("bp_addr", imem_addr, 2);
        instr_ready = 1'b1; cyc(1); instr_ready = 1'b0;
        chk("bp_rereq", imem_req, 1);
        chk("bp_readdr", imem_addr, 2);
        chk("bp_head2", instr_pc, 1);
        instr_ready = 1'b1;
        run_to_halt(50, "bp_halt");
        chk("bp_acks", acks, 4);

        // Three wait states, eight words plus HALT, random backpressure
        do_reset();
        gen_prog(8); ws = 3; check_ws = 1; rand_ready = 1;
        pulse_start();
        run_to_halt(500, "ws3_halt");
        cyc(2);
        chk("ws3_popped", exp_pc, 9);
        chk("ws3_acks", acks, 9);

        // Random programs, wait states and backpressure
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 12);
            gen_prog(n); ws = $urandom_range(0, 3);
            pulse_start();
            run_to_halt(800, "rnd_halt");
            cyc(2);
            chk("rnd_popped", exp_pc, n + 1);
            pulse_start();
            cyc(2);
            chk("rnd_start_ignored", halted, 1);
            chk("rnd_req_idle", imem_req, 0);
        end
        rand_ready = 0; check_ws = 0; ws = 0; instr_ready = 1'b1;

        // Reset while a request is outstanding, then refetch from RESET_PC
        do_reset();
        gen_prog(5); hold_ack = 1;
        pulse_start();
        cyc(3);
        chk("pend_req", imem_req, 1);
        chk("pend_addr", imem_addr, 0);
        rst_n = 1'b0; cyc(1);
        check_reset("mid");
        rst_n = 1'b1; hold_ack = 0;
        exp_pc = 0; exp_fetch = 0; acks = 0;
        pulse_start();
        chk("refetch_addr", imem_addr, 0);
        run_to_halt(100, "refetch_halt");
        cyc(2);
        chk("refetch_popped", exp_pc, 6);

        // Address wrap on the RESET_PC=FFFE instance
        start2 = 1'b1; cyc(1); start2 = 1'b0;
        for (int i = 0; i < 20 && !halted2; i++) cyc(1);
        chk("wrap_halted", halted2, 1);
        chk("wrap_nfetch", fa.size(), 3);
        chk("wrap_f0", fa.size() > 0 ? fa[0] : 16'hDEAD, 16'hFFFE);
        chk("wrap_f1", fa.size() > 1 ? fa[1] : 16'hDEAD, 16'hFFFF);
        chk("wrap_f2", fa.size() > 2 ? fa[2] : 16'hDEAD, 16'h0000);
        chk("wrap_npop", pq.size(), 3);
        chk("wrap_p2", pq.size() > 2 ? pq[2] : 16'hDEAD, 16'h0000);
        chk("wrap_i2", iq.size() > 2 ? iq[2] : 16'hDEAD, 16'hB000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage that sits directly upstream of the opcode decoder (`controlUnit`). It walks the program counter through instruction memory and buffers fetched words in a 2-entry queue. It presents one instruction at a time to decode with a valid/ready handshake. It detects the HALT opcode itself: fetching stops at the HALT word, and `halted` is raised once decode has consumed it.

## Interface
- `ADDR_W`, 16, instruction-memory word-address width
- `INSTR_W`, 16, instruction width; opcode is `instr[INSTR_W-1 -: 4]`
- `RESET_PC`, 0, first fetch address after `start`

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin fetching; sampled only in IDLE
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  word address; stable while `imem_req` is high
- `imem_ack`  in  1  memory returns data this cycle; meaningful only when `imem_req` is high
- `imem_rdata`  in  INSTR_W  instruction word, valid when `imem_ack` is high
- `instr_valid`  out  1  queue head is valid
- `instr_ready`  in  1  decode accepts the head this cycle
- `instr`  out  INSTR_W  queue-head instruction
- `instr_pc`  out  ADDR_W  address of the queue-head instruction
- `opcode`  out  4  `instr` opcode field; feeds decoder `opcode`
- `busy`  out  1  state is FETCH or DRAIN
- `halted`  out  1  state is HALTED

## Operation
- States:
  - IDLE: wait for `start`.
  - FETCH: issue requests.
  - DRAIN: HALT fetched; wait until the queue is empty.
  - HALTED: terminal.
- Transitions:
  - IDLE→FETCH when `start`; `pc` loads `RESET_PC`.
  - FETCH→DRAIN on an `imem_ack` whose `imem_rdata` opcode is 4'b1011.
  - DRAIN→HALTED when the queue is empty.
  - HALTED is left only by reset. `start` is ignored outside IDLE.
- `imem_req` = (state==FETCH) && (count<2). It is decoded from registers only and has no input-to-output path.
  - Once high, it stays high until ack, because only acks raise `count`.
- `imem_addr` = `pc`.
- On `imem_ack`:
  - push {`imem_rdata`, `pc`} into the queue;
  - `pc` ← `pc`+1, modulo 2^ADDR_W; address all-ones wraps to 0 silently.
- At most one outstanding request at any time.
- Queue: 2-entry FIFO, `count` in 0..2.
  - Pop when `instr_valid && instr_ready`.
  - Push and pop in the same cycle is legal at count 1, and at count 2 only as a pop. A push at count 2 cannot occur because `imem_req` is low then.
- `instr_valid` = count≠0. `instr`/`instr_pc` show the head and hold while the consumer is stalled (`instr_ready` low).
- Words acked after HALT do not exist, because no request is issued in DRAIN.
- Reset (any state, including with a request outstanding):
  - state IDLE, `count` 0, `pc` `RESET_PC`;
  - the outstanding request is abandoned and memory must tolerate `imem_req` dropping.
- Reset values: `imem_req` 0, `imem_addr` `RESET_PC`, `instr_valid` 0, `instr` 0, `instr_pc` 0, `opcode` 0 (NOP), `busy` 0, `halted` 0.

## Timing
- `start` high in cycle 0 (IDLE) → `imem_req` high in cycle 1 with address `RESET_PC`.
- Zero-wait memory (ack in the request cycle) → `instr_valid` high in cycle 2.
- Sustained throughput with zero-wait memory and `instr_ready` held high: one instruction per cycle.
- Wait states: `imem_req`/`imem_addr` held for N cycles until ack; ack-to-`instr_valid` latency is 1 cycle.
- HALT acked in cycle k → `imem_req` low from cycle k+1 and state DRAIN.
  - `halted` rises the cycle after the HALT word is popped.
- Backpressure: with `instr_ready` low, the queue fills to 2, then `imem_req` drops.
  - First pop → `imem_req` high again the next cycle.

## Structure
- Shared package `nn_isa_pkg`:
  - opcode constants OP_NOP 0000, OP_ADD 0001, OP_MUL 0010, OP_SINN 0011, OP_MAC 0100, OP_ADDI 1001, OP_HALT 1011, OP_LD 1110, OP_ST 1111;
  - INSTR_W and the opcode field position;
  - fetch state enum {IDLE, FETCH, DRAIN, HALTED}.
- One sub-module, `fetch_fifo`: 2-deep, width INSTR_W+ADDR_W, synchronous active-low reset, push/pop/count/head ports.
- The FSM and PC live in `instr_fetch_unit`.

## Test plan
- Reset with `start` held → all outputs at reset values; `imem_req` 0 until the cycle after reset deasserts and `start` is sampled.
- Zero-wait memory containing ADD, MUL, MAC, HALT at 0..3; `instr_ready`=1 → `instr` sequence with `instr_pc` 0,1,2,3 on consecutive cycles; no request to address 4; `halted`=1 one cycle after HALT is consumed.
- `instr_ready`=0 for 10 cycles → queue holds 2 words (addresses 0,1); `imem_req` low with `imem_addr`=2; one pop → request to address 2 on the next cycle.
- Memory with 3 wait states → `imem_addr` stable for 4 cycles per word; no duplicate or dropped instructions over 8 words.
- `RESET_PC`=16'hFFFE, program NOP, NOP, HALT → fetch addresses FFFE, FFFF, 0000; `instr_pc` wraps to 0.
- `rst_n` low for 1 cycle while a request is pending (ack withheld) → next cycle all outputs at reset values; a new `start` refetches from `RESET_PC`.
